lcd_cmd_decoder: RTL and testbench

LCD_CMD_DECODER -- requirements
Module: lcd_cmd_decoder

---
 rtl/lcd_cmd_decoder.sv | 184 ++++++++++++++++++
 tb/tb_lcd_cmd_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cmd_decoder
// Purpose  : Decodes an LCD-controller byte stream (commands/parameters) into
//            window registers, display flags and a stream of addressed pixels.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_cmd_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [7:0]  D,
    input  logic        dcx,
    output logic        display_on,
    output logic        sleep_out,
    output logic [15:0] sc,
    output logic [15:0] ec,
    output logic [15:0] sp,
    output logic [15:0] ep,
    output logic        pix_valid,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic [15:0] pix_color,
    output logic        err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CASET  = 3'd1;
    localparam logic [2:0] S_PASET  = 3'd2;
    localparam logic [2:0] S_RAM_LO = 3'd3;
    localparam logic [2:0] S_RAM_HI = 3'd4;

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    localparam logic [15:0] EC_RST = 16'd239;
    localparam logic [15:0] EP_RST = 16'd319;

    logic [2:0]  state, state_nxt;
    logic [1:0]  p, p_nxt;
    logic [23:0] shadow;
    logic [7:0]  color_lo;
    logic [15:0] cur_x, cur_y;

    logic cmd_byte, data_byte;
    logic do_swreset, do_sleep, do_on, do_off, do_ramwr, bad_cmd, stray;
    logic shift_par, commit_col, commit_page, latch_lo, pix_fire;

    assign cmd_byte  = wr & ~dcx;
    assign data_byte = wr &  dcx;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            p     <= 2'd0;
        end else begin
            state <= state_nxt;
            p     <= p_nxt;
        end
    end

    // Next-state logic: any command byte aborts and restarts decoding
    always_comb begin
        state_nxt = state;
        p_nxt     = p;
        if (cmd_byte) begin
            p_nxt = 2'd0;
            case (D)
                CMD_CASET: state_nxt = S_CASET;
                CMD_PASET: state_nxt = S_PASET;
                CMD_RAMWR: state_nxt = S_RAM_LO;
                default:   state_nxt = S_IDLE;
            endcase
        end else if (data_byte) begin
            case (state)
                S_CASET, S_PASET: begin
                    p_nxt = p + 2'd1;
                    if (p == 2'd3) state_nxt = S_IDLE;
                end
                S_RAM_LO: state_nxt = S_RAM_HI;
                S_RAM_HI: state_nxt = S_RAM_LO;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode: one-hot actions consumed by the datapath
    always_comb begin
        do_swreset  = cmd_byte && (D == CMD_SWRESET);
        do_sleep    = cmd_byte && (D == CMD_SLPOUT);
        do_on       = cmd_byte && (D == CMD_DISPON);
        do_off      = cmd_byte && (D == CMD_DISPOFF);
        do_ramwr    = cmd_byte && (D == CMD_RAMWR);
        bad_cmd     = cmd_byte && !(D == CMD_NOP    || D == CMD_SWRESET ||
                                    D == CMD_SLPOUT || D == CMD_DISPOFF ||
                                    D == CMD_DISPON || D == CMD_CASET   ||
                                    D == CMD_PASET  || D == CMD_RAMWR);
        stray       = data_byte && (state == S_IDLE);
        shift_par   = data_byte && (state == S_CASET || state == S_PASET) && (p != 2'd3);
        commit_col  = data_byte && (state == S_CASET) && (p == 2'd3);
        commit_page = data_byte && (state == S_PASET) && (p == 2'd3);
        latch_lo    = data_byte && (state == S_RAM_LO);
        pix_fire    = data_byte && (state == S_RAM_HI);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            display_on <= 1'b0;
            sleep_out  <= 1'b0;
            sc         <= 16'd0;
            ec         <= EC_RST;
            sp         <= 16'd0;
            ep         <= EP_RST;
            shadow     <= 24'd0;
            color_lo   <= 8'd0;
            cur_x      <= 16'd0;
            cur_y      <= 16'd0;
            pix_valid  <= 1'b0;
            pix_x      <= 16'd0;
            pix_y      <= 16'd0;
            pix_color  <= 16'd0;
            err        <= 1'b0;
        end else begin
            err       <= bad_cmd | stray;
            pix_valid <= pix_fire;
            if (do_swreset) begin
                display_on <= 1'b0;
                sleep_out  <= 1'b0;
                sc         <= 16'd0;
                ec         <= EC_RST;
                sp         <= 16'd0;
                ep         <= EP_RST;
                shadow     <= 24'd0;
                color_lo   <= 8'd0;
                cur_x      <= 16'd0;
                cur_y      <= 16'd0;
                pix_x      <= 16'd0;
                pix_y      <= 16'd0;
                pix_color  <= 16'd0;
            end else begin
                if (do_sleep) sleep_out  <= 1'b1;
                if (do_on)    display_on <= 1'b1;
                if (do_off)   display_on <= 1'b0;
                if (shift_par) shadow <= {shadow[15:0], D};
                // Window bounds only change once all four bytes have arrived
                if (commit_col) begin
                    sc <= shadow[23:8];
                    ec <= {shadow[7:0], D};
                end
                if (commit_page) begin
                    sp <= shadow[23:8];
                    ep <= {shadow[7:0], D};
                end
                if (latch_lo) color_lo <= D;
                if (do_ramwr) begin
                    cur_x <= sc;
                    cur_y <= sp;
                end
                if (pix_fire) begin
                    pix_x     <= cur_x;
                    pix_y     <= cur_y;
                    pix_color <= {D, color_lo};
                    // >= keeps the walk bounded even when start > end
                    if (cur_x >= ec) begin
                        cur_x <= sc;
                        cur_y <= (cur_y >= ep) ? sp : cur_y + 16'd1;
                    end else begin
                        cur_x <= cur_x + 16'd1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_cmd_decoder
// Purpose  : Directed plus random byte-stream bench for lcd_cmd_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr  = 1'b0;
    logic [7:0]  D   = 8'h00;
    logic        dcx = 1'b0;
    logic        display_on, sleep_out, pix_valid, err;
    logic [15:0] sc, ec, sp, ep, pix_x, pix_y, pix_color;

    int n_vec = 0;
    int n_err = 0;

    lcd_cmd_decoder dut (
        .clk(clk), .rst(rst), .wr(wr), .D(D), .dcx(dcx),
        .display_on(display_on), .sleep_out(sleep_out),
        .sc(sc), .ec(ec), .sp(sp), .ep(ep),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_color(pix_color), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=idle 1=column params 2=page params 3=pixel data
    int          m_mode;
    byte         m_par[$];
    bit          m_have_lo;
    logic [7:0]  m_lo;
    logic        m_disp, m_sleep, m_pv, m_err;
    logic [15:0] m_sc, m_ec, m_sp, m_ep, m_cx, m_cy, m_px, m_py, m_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_par.delete(); m_have_lo = 0; m_lo = 8'h00;
        m_disp = 0; m_sleep = 0;
        m_sc = 0; m_ec = 16'd239; m_sp = 0; m_ep = 16'd319;
        m_cx = 0; m_cy = 0; m_px = 0; m_py = 0; m_pc = 0;
        m_pv = 0; m_err = 0;
    endtask

    task automatic model_byte(input logic is_data, input logic [7:0] b);
        if (!is_data) begin
            m_mode = 0; m_par.delete(); m_have_lo = 0;
            case (b)
                8'h00: ;
                8'h01: begin model_reset(); end
                8'h11: m_sleep = 1;
                8'h28: m_disp = 0;
                8'h29: m_disp = 1;
                8'h2A: m_mode = 1;
                8'h2B: m_mode = 2;
                8'h2C: begin m_cx = m_sc; m_cy = m_sp; m_mode = 3; end
                default: m_err = 1;
            endcase
        end else if (m_mode == 0) begin
            m_err = 1;
        end else if (m_mode == 3) begin
            if (!m_have_lo) begin
                m_lo = b; m_have_lo = 1;
            end else begin
                m_pv = 1; m_px = m_cx; m_py = m_cy; m_pc = {b, m_lo};
                m_have_lo = 0;
                if (m_cx >= m_ec) begin
                    m_cx = m_sc;
                    m_cy = (m_cy >= m_ep) ? m_sp : m_cy + 16'd1;
                end else begin
                    m_cx = m_cx + 16'd1;
                end
            end
        end else begin
            m_par.push_back(b);
            if (m_par.size() == 4) begin
                if (m_mode == 1) begin
                    m_sc = {m_par[0], m_par[1]}; m_ec = {m_par[2], m_par[3]};
                end else begin
                    m_sp = {m_par[0], m_par[1]}; m_ep = {m_par[2], m_par[3]};
                end
                m_par.delete(); m_mode = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".flags"}, {60'd0, display_on, sleep_out, pix_valid, err},
                             {60'd0, m_disp, m_sleep, m_pv, m_err});
        chk({tag, ".win"}, {sc, ec, sp, ep}, {m_sc, m_ec, m_sp, m_ep});
        chk({tag, ".pix"}, {16'd0, pix_x, pix_y, pix_color}, {16'd0, m_px, m_py, m_pc});
    endtask

    // One clock cycle; wr_v=0 gives an idle cycle
    task automatic step(input logic wr_v, input logic dcx_v, input logic [7:0] d_v, input string tag);
        @(negedge clk);
        wr = wr_v; dcx = dcx_v; D = d_v;
        m_pv = 0; m_err = 0;
        if (wr_v) model_byte(dcx_v, d_v);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic cmd(input logic [7:0] b, input string tag);
        step(1'b1, 1'b0, b, tag);
    endtask

    task automatic dat(input logic [7:0] b, input string tag);
        step(1'b1, 1'b1, b, tag);
    endtask

    initial begin
        int cnt;
        logic [7:0] cmds [8];
        cmds = '{8'h00, 8'h01, 8'h11, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 0;

        // Init sequence
        cmd(8'h01, "init_swreset");
        cmd(8'h28, "init_dispoff");
        cmd(8'h11, "init_slpout");
        cmd(8'h29, "init_dispon");
        chk("init_on_sleep", {62'd0, display_on, sleep_out}, 64'd3);

        // Window plus full fill, pixel order from plain arithmetic
        cmd(8'h2A, "caset");
        dat(8'h00, "caset_p"); dat(8'h14, "caset_p"); dat(8'h00, "caset_p"); dat(8'h28, "caset_p");
        cmd(8'h2B, "paset");
        dat(8'h00, "paset_p"); dat(8'h3C, "paset_p"); dat(8'h00, "paset_p"); dat(8'h50, "paset_p");
        cmd(8'h2C, "ramwr");
        cnt = 0;
        for (int i = 0; i < 442; i++) begin
            dat(8'h1E, "fill_lo");
            dat(8'h90, "fill_hi");
            if (pix_valid && i < 441) cnt++;
            if (i == 0 || i == 20 || i == 21 || i == 440 || i == 441)
                chk("fill_xy", {16'd0, pix_x, pix_y, pix_color},
                    {16'd0, 16'(20 + (i % 441) % 21), 16'(60 + (i % 441) / 21), 16'h901E});
        end
        chk("fill_count", 64'(cnt), 64'd441);

        // Partial CASET leaves window untouched
        cmd(8'h2A, "partial_caset");
        dat(8'h00, "partial_p"); dat(8'h05, "partial_p");
        cmd(8'h2C, "partial_ramwr");
        chk("partial_win", {32'd0, sc, ec}, {32'd0, 16'd20, 16'd40});
        dat(8'h01, "partial_lo"); dat(8'h02, "partial_hi");
        chk("partial_x", {48'd0, pix_x}, 64'd20);

        // Abort mid-pixel
        cmd(8'h2C, "abort_ramwr");
        dat(8'hAA, "abort_lo");
        cmd(8'h00, "abort_nop");
        cmd(8'h2C, "abort_ramwr2");
        dat(8'h34, "abort_lo2");
        dat(8'h12, "abort_hi2");
        chk("abort_pix", {15'd0, pix_valid, pix_x, pix_y, pix_color}, {15'd0, 1'b1, 16'd20, 16'd60, 16'h1234});

        // Error pulses
        cmd(8'h5A, "err_cmd");
        chk("err_cmd_pulse", {63'd0, err}, 64'd1);
        step(1'b0, 1'b0, 8'h00, "err_cmd_idle");
        dat(8'h77, "err_stray");
        chk("err_stray_pulse", {63'd0, err}, 64'd1);
        step(1'b0, 1'b0, 8'h00, "err_stray_idle");

        // Reset mid-PASET after 3 params
        cmd(8'h2B, "rst_paset");
        dat(8'h01, "rst_p"); dat(8'h02, "rst_p"); dat(8'h03, "rst_p");
        @(negedge clk);
        rst = 1;
        #1;
        model_reset();
        check_all("rst_async");
        chk("rst_page", {32'd0, sp, ep}, {32'd0, 16'd0, 16'd319});
        @(negedge clk);
        rst = 0;
        dat(8'h04, "rst_next_data");
        chk("rst_next_err", {63'd0, err}, 64'd1);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 15)
                step(1'b0, 1'(($urandom & 1)), 8'($urandom), "rnd_idle");
            else if (r < 35)
                cmd((($urandom & 7) == 0) ? 8'($urandom) : cmds[$urandom_range(2, 7)], "rnd_cmd");
            else
                dat(8'($urandom), "rnd_data");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
